// File: rtl/tt_ctrl_sel_seq_pkg.sv
// Shared constants for the mux-controller select sequencer.
package tt_ctrl_sel_seq_pkg;

  localparam int unsigned TT_SEL_W      = 10;
  localparam int unsigned TT_PULSE_W    = 2;
  localparam int unsigned TT_RST_W      = 4;
  localparam int unsigned TT_SETTLE_W   = 8;

  // Timer width able to hold the largest (duration - 1) load value.
  function automatic int unsigned tmr_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tt_ctrl_seq_timer.sv
// Load-with-value down-counter with a registered zero flag; times every sequencer phase.
module tt_ctrl_seq_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] next_c,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign next_c = cnt_d;
  assign zero_o = zero_q;

endmodule

// File: rtl/tt_ctrl_sel_seq.sv
// Drives the controller's ctrl_sel_rst_n / ctrl_sel_inc / ctrl_ena wires to reach a requested address.
module tt_ctrl_sel_seq
  import tt_ctrl_sel_seq_pkg::*;
#(
  parameter int unsigned PULSE_W  = TT_PULSE_W,
  parameter int unsigned RST_W    = TT_RST_W,
  parameter int unsigned SETTLE_W = TT_SETTLE_W,
  parameter int unsigned ADDR_W   = TT_SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_vld,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  localparam int unsigned TMR_W = tmr_width(PULSE_W, RST_W, SETTLE_W);
  localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_W - 1);
  localparam logic [TMR_W-1:0] RST_LD    = TMR_W'(RST_W - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_OFF, S_RST, S_INC_HI, S_INC_LO, S_SETTLE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pcnt_q, pcnt_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              cur_vld_q, cur_vld_d;
  logic              need_rst_q, need_rst_d;
  logic              ena_lat_q, ena_lat_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              sel_rst_n_q, sel_rst_n_d;
  logic              inc_q, inc_d;
  logic              ena_q, ena_d;

  logic              t_load;
  logic [TMR_W-1:0]  t_val;
  logic [TMR_W-1:0]  t_next;
  logic              t_zero;
  logic              go_inc, go_settle;
  logic              accept;
  logic              req_need_rst;

  tt_ctrl_seq_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (t_load),
    .val_i  (t_val),
    .next_c (t_next),
    .zero_o (t_zero)
  );

  assign accept       = req_valid & ready_q;
  assign req_need_rst = !cur_vld_q || (req_addr < cur_addr_q);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    cur_addr_d = cur_addr_q;
    cur_vld_d  = cur_vld_q;
    need_rst_d = need_rst_q;
    ena_lat_d  = ena_lat_q;
    inc_d      = inc_q;
    ena_d      = ena_q;
    done_d     = 1'b0;
    t_load     = 1'b0;
    t_val      = '0;
    go_inc     = 1'b0;
    go_settle  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_OFF;
          need_rst_d = req_need_rst;
          pcnt_d     = req_need_rst ? req_addr : req_addr - cur_addr_q;
          ena_lat_d  = req_ena;
          ena_d      = 1'b0;
          t_load     = 1'b1;
          t_val      = SETTLE_LD;
        end
      end
      S_OFF: begin
        if (t_zero) begin
          if (need_rst_q) begin
            state_d = S_RST;
            t_load  = 1'b1;
            t_val   = RST_LD;
          end else if (pcnt_q != '0) begin
            go_inc = 1'b1;
          end else begin
            go_settle = 1'b1;
          end
        end
      end
      S_RST: begin
        if (t_zero) begin
          cur_addr_d = '0;
          cur_vld_d  = 1'b1;
          if (pcnt_q != '0) go_inc = 1'b1;
          else              go_settle = 1'b1;
        end
      end
      S_INC_HI: begin
        if (t_zero) begin
          state_d = S_INC_LO;
          inc_d   = 1'b0;
          t_load  = 1'b1;
          t_val   = PULSE_LD;
        end
      end
      S_INC_LO: begin
        if (t_zero) begin
          if (pcnt_q != '0) go_inc = 1'b1;
          else              go_settle = 1'b1;
        end
      end
      S_SETTLE: begin
        if (t_zero) begin
          state_d = S_IDLE;
          ena_d   = ena_lat_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_inc) begin
      state_d    = S_INC_HI;
      inc_d      = 1'b1;
      pcnt_d     = pcnt_q - ADDR_W'(1);
      cur_addr_d = cur_addr_d + ADDR_W'(1);
      t_load     = 1'b1;
      t_val      = PULSE_LD;
    end
    if (go_settle) begin
      state_d = S_SETTLE;
      t_load  = 1'b1;
      t_val   = SETTLE_LD;
    end
  end

  // The counter reset window is shifted one cycle early (last OFF cycle through
  // the second-to-last RST cycle) so rst_n rises a full cycle before the first inc edge.
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    sel_rst_n_d = !(((state_d == S_OFF) && (t_next == '0) && need_rst_d) ||
                    ((state_d == S_RST) && (t_next != '0)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pcnt_q      <= '0;
      cur_addr_q  <= '0;
      cur_vld_q   <= 1'b0;
      need_rst_q  <= 1'b0;
      ena_lat_q   <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      sel_rst_n_q <= 1'b0;
      inc_q       <= 1'b0;
      ena_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      cur_addr_q  <= cur_addr_d;
      cur_vld_q   <= cur_vld_d;
      need_rst_q  <= need_rst_d;
      ena_lat_q   <= ena_lat_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      sel_rst_n_q <= sel_rst_n_d;
      inc_q       <= inc_d;
      ena_q       <= ena_d;
    end
  end

  assign req_ready      = ready_q;
  assign done           = done_q;
  assign cur_addr       = cur_addr_q;
  assign cur_vld        = cur_vld_q;
  assign ctrl_sel_rst_n = sel_rst_n_q;
  assign ctrl_sel_inc   = inc_q;
  assign ctrl_ena       = ena_q;

endmodule
